// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage in-order pipeline.
// Define FWD_HAZARD_FWD_EN for EX operand forwarding; otherwise the unit stalls until producers reach WB.
module fwd_hazard_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  output logic        stall,
  output logic        bubble,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic [15:0] stall_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [1:0]  FWD_RF  = 2'b00;
  localparam logic [1:0]  FWD_WB  = 2'b01;
  localparam logic [1:0]  FWD_MEM = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } tag_t;

  typedef enum logic {RUN, STALL} state_t;

  tag_t       ex_tag, mem_tag, wb_tag, ex_tag_n;
  state_t     state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic       hazard_c;
  logic       unused_tags;

  // A stage produces a register only if it is a real writer of a non-x0 register.
  function automatic logic hits(input tag_t t, input logic [REG_W-1:0] src);
    return t.valid && t.reg_write && (t.rd != '0) && (t.rd == src);
  endfunction

  // Not every tag field feeds decisions in every build.
  assign unused_tags = ^{mem_tag, wb_tag, ex_tag.rs1, ex_tag.rs2};

  always_comb begin
    hazard_c  = 1'b0;
    forward_a = FWD_RF;
    forward_b = FWD_RF;
`ifdef FWD_HAZARD_FWD_EN
    hazard_c = id_valid && ex_tag.mem_read &&
               (hits(ex_tag, id_rs1) || hits(ex_tag, id_rs2));
    if (hits(mem_tag, ex_tag.rs1))     forward_a = FWD_MEM;
    else if (hits(wb_tag, ex_tag.rs1)) forward_a = FWD_WB;
    if (hits(mem_tag, ex_tag.rs2))     forward_b = FWD_MEM;
    else if (hits(wb_tag, ex_tag.rs2)) forward_b = FWD_WB;
`else
    // WB is excluded: the register file is write-before-read.
    hazard_c = id_valid &&
               (hits(ex_tag, id_rs1) || hits(ex_tag, id_rs2) ||
                hits(mem_tag, id_rs1) || hits(mem_tag, id_rs2));
`endif
    // Flush kills the stalled instruction; reset wins over everything.
    stall  = hazard_c && !flush && !reset;
    bubble = stall;
  end

  always_comb begin
    ex_tag_n = '0;
    state_n  = state;
    cnt_n    = stall_cnt;
    if (!(stall || flush || !id_valid))
      ex_tag_n = '{valid: 1'b1, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                   reg_write: id_reg_write, mem_read: id_mem_read};
    case (state)
      RUN:     if (stall)  state_n = STALL;
      STALL:   if (!stall) state_n = RUN;
      default: state_n = RUN;
    endcase
    if (stall && (stall_cnt != {CNT_W{1'b1}}))
      cnt_n = stall_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_tag    <= '0;
      mem_tag   <= '0;
      wb_tag    <= '0;
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      ex_tag    <= ex_tag_n;
      mem_tag   <= ex_tag;
      wb_tag    <= mem_tag;
      state     <= state_n;
      stall_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit; scenario set follows the FWD_HAZARD_FWD_EN build setting.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset, id_valid, id_reg_write, id_mem_read, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall, bubble;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] stall_cnt;

  typedef struct {
    int          step;
    logic        stall;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .bubble(bubble), .forward_a(forward_a), .forward_b(forward_b),
    .stall_cnt(stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one ID-stage cycle, queue its expected outputs, then compare at the falling edge.
  task automatic cyc(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rw, input logic mr,
                     input logic fl, input logic rst,
                     input logic es, input logic [1:0] efa, input logic [1:0] efb,
                     input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    step++;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl; reset = rst;
    exp_q.push_back('{step: step, stall: es, fa: efa, fb: efb, cnt: ecnt});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq($sformatf("s%0d.stall", e.step), 32'(stall), 32'(e.stall));
      check_eq($sformatf("s%0d.bubble", e.step), 32'(bubble), 32'(e.stall));
      check_eq($sformatf("s%0d.fwd_a", e.step), 32'(forward_a), 32'(e.fa));
      check_eq($sformatf("s%0d.fwd_b", e.step), 32'(forward_b), 32'(e.fb));
      check_eq($sformatf("s%0d.cnt", e.step), 32'(stall_cnt), 32'(e.cnt));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    repeat (2) @(posedge clk);
`ifdef FWD_HAZARD_FWD_EN
    //   v  rs1 rs2 rd rw mr fl rst  stall fa     fb     cnt
    cyc(1, 1,  2,  5, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // add x5
    cyc(1, 5,  1,  6, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // sub x6,x5,x1
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b10, 2'b00, 0);  // sub in EX: MEM fwd
    cyc(1, 1,  2,  7, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // add x7
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b00, 2'b00, 0);
    cyc(1, 1,  7,  8, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // or x8,x1,x7
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b00, 2'b01, 0);  // or in EX: WB fwd
    cyc(1, 1,  2,  5, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // add x5
    cyc(1, 3,  4,  5, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // add x5 again
    cyc(1, 5,  5,  9, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // use x5
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b10, 2'b10, 0);  // MEM beats WB
    cyc(1, 1,  0,  5, 1, 1, 0, 0,   0, 2'b00, 2'b00, 0);  // lw x5
    cyc(1, 5,  5,  6, 1, 0, 0, 0,   1, 2'b00, 2'b00, 0);  // load-use stall
    cyc(1, 5,  5,  6, 1, 0, 0, 0,   0, 2'b00, 2'b00, 1);  // replay after stall
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b01, 2'b01, 1);  // load value from WB
    cyc(1, 1,  2,  0, 1, 0, 0, 0,   0, 2'b00, 2'b00, 1);  // add x0
    cyc(1, 0,  0, 10, 1, 0, 0, 0,   0, 2'b00, 2'b00, 1);  // use x0
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b00, 2'b00, 1);  // no x0 forward
    cyc(1, 1,  0,  5, 1, 1, 0, 0,   0, 2'b00, 2'b00, 1);  // lw x5
    cyc(1, 5,  5,  6, 1, 0, 1, 0,   0, 2'b00, 2'b00, 1);  // flush beats load-use
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b00, 2'b00, 1);  // EX holds a bubble
    cyc(1, 1,  0,  7, 1, 1, 0, 0,   0, 2'b00, 2'b00, 1);  // lw x7
    cyc(1, 7,  0, 11, 1, 0, 0, 0,   1, 2'b00, 2'b00, 1);  // load-use stall
    cyc(1, 7,  0, 11, 1, 0, 0, 1,   0, 2'b00, 2'b00, 2);  // reset mid-stall
    cyc(1, 7,  0, 11, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // cleared by reset
`else
    //   v  rs1 rs2 rd rw mr fl rst  stall fa     fb     cnt
    cyc(1, 1,  2,  5, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // add x5
    cyc(1, 5,  1,  6, 1, 0, 0, 0,   1, 2'b00, 2'b00, 0);  // producer in EX
    cyc(1, 5,  1,  6, 1, 0, 0, 0,   1, 2'b00, 2'b00, 1);  // producer in MEM
    cyc(1, 5,  1,  6, 1, 0, 0, 0,   0, 2'b00, 2'b00, 2);  // producer in WB: go
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b00, 2'b00, 2);
    cyc(1, 1,  2,  7, 1, 0, 0, 0,   0, 2'b00, 2'b00, 2);  // add x7
    cyc(0, 0,  0,  0, 0, 0, 0, 0,   0, 2'b00, 2'b00, 2);
    cyc(1, 1,  7,  8, 1, 0, 0, 0,   1, 2'b00, 2'b00, 2);  // two ahead: 1 stall
    cyc(1, 1,  7,  8, 1, 0, 0, 0,   0, 2'b00, 2'b00, 3);
    cyc(1, 1,  2,  0, 1, 0, 0, 0,   0, 2'b00, 2'b00, 3);  // add x0
    cyc(1, 0,  0,  9, 1, 0, 0, 0,   0, 2'b00, 2'b00, 3);  // use x0 behind EX
    cyc(1, 0,  3, 10, 1, 0, 0, 0,   0, 2'b00, 2'b00, 3);  // use x0 behind MEM
    cyc(1, 1,  2,  5, 1, 0, 0, 0,   0, 2'b00, 2'b00, 3);  // add x5
    cyc(1, 5,  1,  6, 1, 0, 1, 0,   0, 2'b00, 2'b00, 3);  // flush beats hazard
    cyc(1, 6,  4, 12, 1, 0, 0, 0,   0, 2'b00, 2'b00, 3);  // killed x6 writer gone
    cyc(1, 12, 0, 13, 1, 0, 0, 0,   1, 2'b00, 2'b00, 3);  // stall on x12
    cyc(1, 12, 0, 13, 1, 0, 0, 1,   0, 2'b00, 2'b00, 4);  // reset mid-stall
    cyc(1, 12, 0, 13, 1, 0, 0, 0,   0, 2'b00, 2'b00, 0);  // cleared by reset
`endif
    if (exp_q.size() != 0) check_eq("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 The block SHALL have these ports: id_valid input 1, ID stage holds a real instruction.
REQ-003 id_rs1, id_rs2, id_rd SHALL be input 5 each: the source and destination register numbers of the ID instruction.
REQ-004 id_reg_write, id_mem_read SHALL be input 1 each: the ID instruction writes rd / is a load.
REQ-005 flush SHALL be input 1: a taken branch or jump resolved in EX; it kills the ID and EX instructions.
REQ-006 stall SHALL be output 1, combinational: hold the PC and IF/ID registers.
REQ-007 bubble SHALL be output 1, combinational: zero the ID/EX control signals.
REQ-008 forward_a, forward_b SHALL be output 2 each, combinational: the select lines for the EX-operand 3:1 muxes. 00 = register-file value, 01 = WB result, 10 = MEM (EX/MEM ALU) result; 11 is never driven.
REQ-009 stall_cnt SHALL be output 16, registered: count of stall cycles.

Function
REQ-010 The block SHALL hold three internal stage tags: EX, MEM and WB. Each tag holds {valid, rs1, rs2, rd, reg_write, mem_read}.
REQ-011 On each clock edge when reset=0: WB<=MEM; MEM<=EX; EX<=ID fields, unless (stall | flush | !id_valid), in which case EX<=an all-zero bubble tag.
REQ-012 flush SHALL also write a bubble into EX on the following edge. flush SHALL override stall in the same cycle: no stall is asserted and stall_cnt does not increment.
REQ-013 A tag SHALL match a source register only when: tag.valid=1, tag.reg_write=1, tag.rd!=0, and tag.rd equals that source.
REQ-014 forward_a SHALL be 10 if MEM matches EX.rs1; else 01 if WB matches EX.rs1; else 00. MEM has priority over WB on a double hit. forward_b follows the same rule using EX.rs2.
REQ-015 Load-use: stall=1 when id_valid=1, EX matches id_rs1 or id_rs2, and EX.mem_read=1.
REQ-016 bubble SHALL equal stall.
REQ-017 A load-use hazard SHALL produce exactly one stall cycle. After the stall, the dependent instruction enters EX with forward=01 for the load value, which by then is in WB.
REQ-018 Register x0 SHALL never cause a stall or a forward.
REQ-019 Stall FSM: RUN -> STALL when the stall condition is true at the clock edge; STALL -> RUN when it is false. The state is used only to count stall cycles.
REQ-020 stall_cnt SHALL increment by 1 on each edge where stall=1, and SHALL saturate at 16'hFFFF.
REQ-021 The register file SHALL be treated as write-before-read. A WB writer therefore never causes a stall against ID.

Reset
REQ-022 reset=1 at a clock edge SHALL clear all tags to bubble, return the FSM to RUN, and set stall_cnt to 0.
REQ-023 For the whole cycle after reset, outputs SHALL be stall=0, bubble=0, forward_a=00, forward_b=00.
REQ-024 reset SHALL override flush and stall in the same cycle. An in-flight stall is abandoned with no extra bubble.

Configuration
REQ-025 The macro FWD_HAZARD_FWD_EN SHALL select the forwarding mode.
REQ-026 When FWD_HAZARD_FWD_EN is defined, the block SHALL behave as REQ-014 to REQ-017.
REQ-027 When FWD_HAZARD_FWD_EN is undefined: forward_a and forward_b SHALL be tied to 00. stall SHALL assert while EX or MEM matches id_rs1 or id_rs2, for any instruction type. A producer immediately ahead of its consumer SHALL therefore cost 2 stall cycles, and a producer two ahead SHALL cost 1.

Verification
REQ-028 Scenario 1 (forwarding on): add x5 followed by sub x6,x5,x1 -> sub in EX has forward_a=10; stall never asserts.
REQ-029 Scenario 2 (forwarding on): add x5, then nop, then or x7,x1,x5 -> or in EX has forward_b=01.
REQ-030 Scenario 3: add x5, then add x5, then use x5 -> forward_a=10 (MEM wins over WB).
REQ-031 Scenario 4: lw x5 followed by add x6,x5,x5 -> stall=bubble=1 for exactly 1 cycle, then forward_a=forward_b=01; stall_cnt=1.
REQ-032 Scenario 5: writer to x0 followed by a consumer of x0 -> forward=00 and stall=0 throughout. Asserting reset during a load-use stall -> next cycle stall=0 and stall_cnt=0.
REQ-033 Scenario 6: flush asserted in the same cycle as a load-use condition -> stall=0, EX receives a bubble, and stall_cnt is unchanged. With FWD_HAZARD_FWD_EN undefined, an add-then-use sequence -> 2 stall cycles and forward stays 00.
